dequantization: RTL

- Converts a signed quantized integer of runtime-selectable bitwidth back to bfloat16 by multiplying it with a bfloat16 scale.
- Inverse of the quantization path. It sits on the output side of the integer compute array, ahead of the floating-point accumulation and activation logic.
- Fully pipelined with fixed latency. Accepts one value per cycle using the same strobe handshake as the quantizer.

---
 rtl/dequantization_if.sv | 24 ++
 rtl/dequantization.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dequantization_if.sv
// Strobe-handshake bundle between the integer compute array output and the
// dequantizer: quantized value, bitwidth and scale in; bfloat16 result out.
interface dequantization_if #(
  parameter int MAX_BITWIDTH_QUANTIZED_DATA = 16
);
  localparam int BW_W = $clog2(MAX_BITWIDTH_QUANTIZED_DATA) + 1;

  logic                                   values_rdy;
  logic [BW_W-1:0]                        bitwidth;
  logic [MAX_BITWIDTH_QUANTIZED_DATA-1:0] qvalue;
  logic [15:0]                            scale_fp;
  logic                                   result_rdy;
  logic [15:0]                            result;

  modport master (
    output values_rdy, bitwidth, qvalue, scale_fp,
    input  result_rdy, result
  );

  modport slave (
    input  values_rdy, bitwidth, qvalue, scale_fp,
    output result_rdy, result
  );
endinterface

// File: rtl/dequantization.sv
// Dequantizer: signed integer of runtime bitwidth times a bfloat16 scale,
// producing bfloat16. Three register stages: int->bf16, multiply, round/pack.
// The integer is rounded to bf16 first, and the product is rounded again.
module dequantization #(
  parameter int MAX_BITWIDTH_QUANTIZED_DATA = 16
) (
  input  logic             clk,
  input  logic             rstn,
  dequantization_if.slave  bus
);
  localparam int MAXW = MAX_BITWIDTH_QUANTIZED_DATA;
  localparam int BW_W = $clog2(MAXW) + 1;

  typedef struct packed {
    logic       sign;
    logic       zero;
    logic [7:0] exp;
    logic [7:0] mant;   // includes the hidden one at bit 7
  } conv_t;

  // Sign-extend the active bits, then convert to bf16 with round-to-nearest-even.
  function automatic conv_t int_to_bf(input logic [MAXW-1:0] q, input logic [BW_W-1:0] bw);
    conv_t                  r;
    logic [BW_W-1:0]        eff;
    int                     sh;
    logic signed [MAXW-1:0] sx;
    logic [MAXW-1:0]        absv;
    logic [15:0]            mag;
    logic [3:0]             p;
    logic [15:0]            norm;
    logic                   rup;
    logic [8:0]             rounded;
    if ((bw == '0) || (bw > BW_W'(MAXW))) eff = BW_W'(MAXW);
    else                                  eff = bw;
    sh   = MAXW - int'(eff);
    sx   = $signed(q << sh) >>> sh;
    absv = sx[MAXW-1] ? MAXW'(-sx) : MAXW'(sx);
    mag  = 16'(absv);
    p    = 4'd0;
    for (int i = 0; i < 16; i++) begin
      p = mag[i] ? 4'(i) : p;
    end
    norm    = mag << (4'd15 - p);
    rup     = norm[7] & ((|norm[6:0]) | norm[8]);
    rounded = {1'b0, norm[15:8]} + {8'd0, rup};
    r.sign  = sx[MAXW-1];
    r.zero  = (mag == 16'd0);
    if (rounded[8]) begin
      r.mant = 8'h80;
      r.exp  = 8'd128 + {4'd0, p};
    end else begin
      r.mant = rounded[7:0];
      r.exp  = 8'd127 + {4'd0, p};
    end
    return r;
  endfunction

  // Normalize the 8x8 significand product, round to nearest-even and pack.
  function automatic logic [15:0] norm_pack(input logic sign, input logic signed [9:0] exp_raw,
                                            input logic [15:0] prod);
    logic [15:0]       norm;
    logic signed [9:0] e;
    logic              rup;
    logic [8:0]        rounded;
    logic [6:0]        frac;
    logic [15:0]       r;
    norm    = prod[15] ? prod : (prod << 1);
    e       = exp_raw + (prod[15] ? 10'sd1 : 10'sd0);
    rup     = norm[7] & ((|norm[6:0]) | norm[8]);
    rounded = {1'b0, norm[15:8]} + {8'd0, rup};
    if (rounded[8]) begin
      frac = 7'd0;
      e    = e + 10'sd1;
    end else begin
      frac = rounded[6:0];
    end
    if (e >= 10'sd255)    r = {sign, 8'hFF, 7'd0};
    else if (e <= 10'sd0) r = {sign, 15'd0};
    else                  r = {sign, e[7:0], frac};
    return r;
  endfunction

  // Stage 1 registers
  logic        s1_valid_r;
  conv_t       s1_conv_r;
  logic [15:0] s1_scale_r;

  // Stage 2 signals/registers
  logic [7:0]        s_exp_s;
  logic              s_nan_s, s_inf_s, s_zero_s, sign_s;
  logic [15:0]       prod_s;
  logic signed [9:0] exp_raw_s;
  logic              special_s;
  logic [15:0]       special_val_s;
  logic              s2_valid_r, s2_sign_r, s2_special_r;
  logic signed [9:0] s2_exp_r;
  logic [15:0]       s2_prod_r, s2_special_val_r;

  // Stage 3 signals/registers
  logic [15:0] packed_s;
  logic        result_rdy_r;
  logic [15:0] result_r;

  // Stage 1: capture strobed inputs as a bf16-converted integer plus the scale.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_r <= 1'b0;
      s1_conv_r  <= '0;
      s1_scale_r <= 16'h0000;
    end else begin
      s1_valid_r <= bus.values_rdy;
      if (bus.values_rdy) begin
        s1_conv_r  <= int_to_bf(bus.qvalue, bus.bitwidth);
        s1_scale_r <= bus.scale_fp;
      end else begin
        s1_conv_r  <= s1_conv_r;
        s1_scale_r <= s1_scale_r;
      end
    end
  end

  assign s_exp_s   = s1_scale_r[14:7];
  assign s_zero_s  = (s_exp_s == 8'd0);
  assign s_nan_s   = (s_exp_s == 8'hFF) && (s1_scale_r[6:0] != 7'd0);
  assign s_inf_s   = (s_exp_s == 8'hFF) && (s1_scale_r[6:0] == 7'd0);
  assign sign_s    = s1_conv_r.sign ^ s1_scale_r[15];
  assign prod_s    = 16'(s1_conv_r.mant) * 16'({1'b1, s1_scale_r[6:0]});
  assign exp_raw_s = $signed({2'b00, s1_conv_r.exp}) + $signed({2'b00, s_exp_s}) - 10'sd127;

  // Special-case resolution in priority order: NaN, inf*0, inf, int zero, scale zero.
  always_comb begin
    special_s     = 1'b0;
    special_val_s = 16'h0000;
    if (s_nan_s) begin
      special_s     = 1'b1;
      special_val_s = 16'h7FC0;
    end else if (s_inf_s && s1_conv_r.zero) begin
      special_s     = 1'b1;
      special_val_s = 16'h7FC0;
    end else if (s_inf_s) begin
      special_s     = 1'b1;
      special_val_s = {sign_s, 8'hFF, 7'd0};
    end else if (s1_conv_r.zero) begin
      special_s     = 1'b1;
      special_val_s = 16'h0000;
    end else if (s_zero_s) begin
      special_s     = 1'b1;
      special_val_s = {sign_s, 15'd0};
    end else begin
      special_s     = 1'b0;
      special_val_s = 16'h0000;
    end
  end

  // Stage 2: register the raw product, exponent and any special outcome.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid_r       <= 1'b0;
      s2_sign_r        <= 1'b0;
      s2_exp_r         <= 10'sd0;
      s2_prod_r        <= 16'h0000;
      s2_special_r     <= 1'b0;
      s2_special_val_r <= 16'h0000;
    end else begin
      s2_valid_r       <= s1_valid_r;
      s2_sign_r        <= sign_s;
      s2_exp_r         <= exp_raw_s;
      s2_prod_r        <= prod_s;
      s2_special_r     <= special_s;
      s2_special_val_r <= special_val_s;
    end
  end

  assign packed_s = s2_special_r ? s2_special_val_r : norm_pack(s2_sign_r, s2_exp_r, s2_prod_r);

  // Stage 3: output strobe follows the pipeline; result holds between strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      result_rdy_r <= 1'b0;
      result_r     <= 16'h0000;
    end else begin
      result_rdy_r <= s2_valid_r;
      if (s2_valid_r) result_r <= packed_s;
      else            result_r <= result_r;
    end
  end

  assign bus.result_rdy = result_rdy_r;
  assign bus.result     = result_r;
endmodule
